serial_adder_sub: RTL and testbench
===================================

Name: serial_adder_sub

Overview:
- Parametrised, bit-serial adder/subtractor.
- Successor to the combinational 3-bit ripple adder built from half/full-adder cells.
- Reuses a single full-adder cell, one bit per clock, over WIDTH cycles.
- Adds a start/busy/done handshake, an add/subtract mode, and carry and signed-overflow flags.
- Sits as the arithmetic engine behind the lab's multi-cycle datapath exercises.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result, registered, held until the next completion.
- carry  output  1  carry out of the MSB; for subtraction, 1 means no borrow.
- overflow  output  1  two's-complement overflow of the operation.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy=0, done=0, sum=0, carry=0, overflow=0.
  - Internal shift registers, carry flop and bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch opA=a, opB=(sub ? ~b : b), cin=sub, cnt=0; go to RUN.
  - busy=1 from E0.
- RUN, at each edge E1..EWIDTH:
  - Full-adder cell computes s=opA[0]^opB[0]^c and cout=majority(opA[0],opB[0],c).
  - s shifts into the MSB of the result shift register; opA and opB shift right; c<=cout; cnt++.
  - At the edge processing bit WIDTH-2, capture cMSBin = cout (the carry into the MSB).
  - At EWIDTH (cnt==WIDTH-1 before the edge): go to DONE.
  - Also at EWIDTH: sum<=completed shift register, carry<=final cout, overflow<=cMSBin^final cout.
  - Also at EWIDTH: done<=1, busy<=0.
- Latency: done is high in the cycle after edge EWIDTH, i.e. exactly WIDTH clocks after the start-sampling edge.
- Throughput: one operation per WIDTH+1 cycles (back-to-back via DONE), or WIDTH+2 cycles via IDLE.
- DONE (exactly one cycle):
  - start=1: accepted exactly as in IDLE; go to RUN; done drops.
  - Otherwise go to IDLE; done drops.
- start in RUN is ignored; the operands and operation in flight are unaffected.
- sum/carry/overflow change only at completion; they never show partial results.
- Width rules:
  - sum is modulo 2^WIDTH.
  - Subtraction is a + ~b + 1.
  - carry=0 on subtraction means a<b (unsigned borrow).
- Reset mid-RUN: immediate abort to IDLE; all outputs 0; no done pulse.
- a, b and sub are don't-care except at the start-sampling edge.

Decomposition:
- Shared package or header holds:
  - State encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Counter width constant CNTW = clog2(WIDTH).
- One sub-module, full_adder_cell (a, b, cin -> s, cout), pure combinational.
- Instantiated once and time-multiplexed; the FSM, shift registers and flag logic stay in serial_adder_sub.

Test Plan:
- WIDTH=8, a=0x7F, b=0x01, sub=0, start pulse -> busy for 8 cycles, done exactly 8 clocks after the start edge; sum=0x80, carry=0, overflow=1.
- WIDTH=8, a=0xFF, b=0xFF, sub=0 -> sum=0xFE, carry=1, overflow=0.
- WIDTH=8, a=0x00, b=0x01, sub=1 -> sum=0xFF, carry=0 (borrow), overflow=0.
- WIDTH=8, a=0x80, b=0x01, sub=1 -> sum=0x7F, carry=1, overflow=1.
- WIDTH=8, start a=0x10/b=0x20, then a second start with other operands during RUN -> ignored; result sum=0x30.
- WIDTH=8, start in DONE -> new op accepted and busy re-asserted.
- rst during RUN -> outputs 0 immediately, no done pulse.
- WIDTH=3, exhaustive 64 (a,b) pairs in both modes -> {carry,sum} matches the 4-bit combinational reference, and overflow matches the signed check for every pair.

Source files
------------

// File: rtl/serial_adder_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encodings
// and the bit-counter width helper.
package serial_adder_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // CNTW = clog2(WIDTH); clamped to 1 so a counter is never zero bits wide.
   function automatic int cntWidth(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_sub_full_adder.sv
// Single-bit full-adder cell, time-multiplexed across all bit positions
// of the serial adder/subtractor.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock,
// LSB first, with a start/busy/done handshake and carry/overflow flags.
module serial_adder_sub
   import serial_adder_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int CNTW = cntWidth(WIDTH);
   localparam logic [CNTW-1:0] LAST_BIT   = CNTW'(WIDTH - 1);
   localparam logic [CNTW-1:0] MSB_IN_BIT = CNTW'(WIDTH - 2);

   state_e           stateQ;
   logic [WIDTH-1:0] opAQ, opBQ, resQ, sumQ;
   logic [CNTW-1:0]  cntQ;
   logic             cQ, cMsbInQ, busyQ, doneQ, carryQ, ovfQ;

   logic             faS, faCout;
   logic [WIDTH-1:0] resD;

   full_adder_cell u_fa (
      .a    (opAQ[0]),
      .b    (opBQ[0]),
      .cin  (cQ),
      .s    (faS),
      .cout (faCout)
   );

   // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
   assign resD = {faS, resQ[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ  <= IDLE;
         opAQ    <= '0;
         opBQ    <= '0;
         resQ    <= '0;
         sumQ    <= '0;
         cntQ    <= '0;
         cQ      <= 1'b0;
         cMsbInQ <= 1'b0;
         busyQ   <= 1'b0;
         doneQ   <= 1'b0;
         carryQ  <= 1'b0;
         ovfQ    <= 1'b0;
      end else begin
         case (stateQ)
            IDLE, DONE: begin
               doneQ <= 1'b0;
               if (start) begin
                  // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                  opAQ   <= a;
                  opBQ   <= sub ? ~b : b;
                  cQ     <= sub;
                  cntQ   <= '0;
                  busyQ  <= 1'b1;
                  stateQ <= RUN;
               end else begin
                  stateQ <= IDLE;
               end
            end
            RUN: begin
               resQ <= resD;
               opAQ <= opAQ >> 1;
               opBQ <= opBQ >> 1;
               cQ   <= faCout;
               cntQ <= cntQ + CNTW'(1);
               if (cntQ == MSB_IN_BIT) begin
                  cMsbInQ <= faCout;
               end
               // Overflow is the carry into the MSB differing from the carry out of it.
               if (cntQ == LAST_BIT) begin
                  sumQ   <= resD;
                  carryQ <= faCout;
                  ovfQ   <= cMsbInQ ^ faCout;
                  doneQ  <= 1'b1;
                  busyQ  <= 1'b0;
                  stateQ <= DONE;
               end
            end
            default: begin
               stateQ <= IDLE;
               busyQ  <= 1'b0;
               doneQ  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busyQ;
   assign done     = doneQ;
   assign sum      = sumQ;
   assign carry    = carryQ;
   assign overflow = ovfQ;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench: directed vector table on an 8-bit instance, handshake
// corner sequences, and an exhaustive sweep of a 3-bit instance.
module tb_serial_adder_sub;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, sub;
   logic [7:0] a, b;
   logic       busy, done, carry, overflow;
   logic [7:0] sum;

   logic       rst3, start3, sub3;
   logic [2:0] a3, b3;
   logic       busy3, done3, carry3, overflow3;
   logic [2:0] sum3;

   int totalChecks  = 0;
   int passedChecks = 0;

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] expSum;
      logic       expCarry;
      logic       expOvf;
   } vec_t;

   serial_adder_sub #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carry    (carry),
      .overflow (overflow)
   );

   serial_adder_sub #(.WIDTH(3)) dut3 (
      .clk      (clk),
      .rst      (rst3),
      .start    (start3),
      .sub      (sub3),
      .a        (a3),
      .b        (b3),
      .busy     (busy3),
      .done     (done3),
      .sum      (sum3),
      .carry    (carry3),
      .overflow (overflow3)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) passedChecks++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Drives one start pulse, samples the accept edge, then scrambles the operands.
   task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vsub);
      start = 1'b1;
      a     = va;
      b     = vb;
      sub   = vsub;
      @(posedge clk); #1;
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      sub   = 1'($urandom);
   endtask

   // Called #1 after the accept edge; walks edges E1..E8 and checks timing and result.
   task automatic waitResult(input string name, input logic [7:0] expSum,
                             input logic expCarry, input logic expOvf,
                             input logic [7:0] prevSum);
      logic timingOk = 1'b1;
      logic holdOk   = 1'b1;
      if (!(busy && !done)) timingOk = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i < 8) begin
            if (!(busy && !done)) timingOk = 1'b0;
            if (sum !== prevSum) holdOk = 1'b0;
         end else begin
            if (!(!busy && done)) timingOk = 1'b0;
         end
      end
      checkOutput({name, " timing"}, 32'(timingOk), 32'd1);
      checkOutput({name, " hold"},   32'(holdOk),   32'd1);
      checkOutput({name, " sum"},    32'(sum),      32'(expSum));
      checkOutput({name, " flags"},  32'({carry, overflow}), 32'({expCarry, expOvf}));
   endtask

   initial begin
      vec_t vecs[8];
      logic [7:0] lastSum;
      logic       sawDone;
      logic [3:0] ref4;
      int         sa, sb, sr;
      logic       refOvf;

      vecs[0] = '{"add 7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[1] = '{"add FF+FF", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
      vecs[2] = '{"sub 00-01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{"sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[4] = '{"add 10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
      vecs[5] = '{"sub 05-05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{"sub 7F-FF", 8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[7] = '{"add 00+00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      rst3 = 1'b1; start3 = 1'b0; sub3 = 1'b0; a3 = '0; b3 = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset outputs", 32'({busy, done, carry, overflow, sum}), 32'd0);
      rst = 1'b0; rst3 = 1'b0;
      @(posedge clk); #1;

      $display("[TB] directed vectors, WIDTH=8");
      lastSum = 8'h00;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub);
         waitResult(vecs[i].name, vecs[i].expSum, vecs[i].expCarry, vecs[i].expOvf, lastSum);
         lastSum = vecs[i].expSum;
         @(posedge clk); #1;
         checkOutput({vecs[i].name, " done drops"}, 32'({busy, done}), 32'd0);
      end

      $display("[TB] start during RUN ignored");
      applyStimulus(8'h10, 8'h20, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1; a = 8'hAA; b = 8'h11; sub = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      sawDone = 1'b0;
      for (int i = 4; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i < 8 && done) sawDone = 1'b1;
      end
      checkOutput("ignored start done at E8", 32'({sawDone, done}), 32'b01);
      checkOutput("ignored start sum", 32'({carry, overflow, sum}), 32'({1'b0, 1'b0, 8'h30}));

      $display("[TB] back-to-back start from DONE");
      start = 1'b1; a = 8'h7F; b = 8'h01; sub = 1'b0;
      @(posedge clk); #1;
      checkOutput("DONE restart busy", 32'({busy, done}), 32'b10);
      start = 1'b0;
      lastSum = 8'h30;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("DONE restart result", 32'({done, carry, overflow, sum}), 32'({1'b1, 1'b0, 1'b1, 8'h80}));
      @(posedge clk); #1;

      $display("[TB] reset during RUN");
      applyStimulus(8'h01, 8'h02, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("async reset outputs", 32'({busy, done, carry, overflow, sum}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      sawDone = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy) sawDone = 1'b1;
      end
      checkOutput("no done after reset", 32'(sawDone), 32'd0);

      $display("[TB] exhaustive sweep, WIDTH=3");
      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
               start3 = 1'b1; a3 = 3'(x); b3 = 3'(y); sub3 = 1'(m);
               @(posedge clk); #1;
               start3 = 1'b0;
               repeat (3) @(posedge clk);
               #1;
               ref4 = (m == 0) ? 4'(x + y) : 4'(x + (7 - y) + 1);
               sa = (x >= 4) ? x - 8 : x;
               sb = (y >= 4) ? y - 8 : y;
               sr = (m == 0) ? sa + sb : sa - sb;
               refOvf = (sr < -4) || (sr > 3);
               checkOutput($sformatf("w3 %s %0d,%0d result", (m == 0) ? "add" : "sub", x, y),
                           32'({done3, carry3, sum3}), 32'({1'b1, ref4}));
               checkOutput($sformatf("w3 %s %0d,%0d overflow", (m == 0) ? "add" : "sub", x, y),
                           32'(overflow3), 32'(refOvf));
            end
         end
      end

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
